// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//   Groups every non-clock/reset signal of the multicycle control unit.
//   master : control unit side (drives strobes/selects, reads opcode/flags)
//   slave  : environment side (IR, datapath flags, memory/IO arbiter)
//
//   opcode[5:0]              IR opcode, valid from DECODE onward
//   zero/sign/carry/overflow registered ALU flags
//   mem_ready                single-cycle memory/IO completion
//   resume                   level request to leave HALTED
//   ir_load                  capture instruction
//   s_pc[1:0]                PC source: 00 +1, 01 immediate, 10 stack
//   s_wd3[1:0]               write-back source: 00 ALU, 01 imm, 10 memory
//   s_addr, s_io_wr          address / IO-data select
//   op_alu[2:0]              ALU function
//   we3, we_flags, push, pop, enable_pc   single-cycle strobes
//   read, write, mem_req     memory request, held through MEM
//   halted                   high in HALTED
//   fault[1:0]               sticky: 00 none, 01 ovf, 10 unf, 11 watchdog
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic       carry;
    logic       overflow;
    logic       mem_ready;
    logic       resume;
    logic       ir_load;
    logic [1:0] s_pc;
    logic [1:0] s_wd3;
    logic       s_addr;
    logic       s_io_wr;
    logic [2:0] op_alu;
    logic       we3;
    logic       we_flags;
    logic       push;
    logic       pop;
    logic       enable_pc;
    logic       read;
    logic       write;
    logic       mem_req;
    logic       halted;
    logic [1:0] fault;

    modport master (
        input  opcode, zero, sign, carry, overflow, mem_ready, resume,
        output ir_load, s_pc, s_wd3, s_addr, s_io_wr, op_alu, we3, we_flags,
               push, pop, enable_pc, read, write, mem_req, halted, fault
    );

    modport slave (
        output opcode, zero, sign, carry, overflow, mem_ready, resume,
        input  ir_load, s_pc, s_wd3, s_addr, s_io_wr, op_alu, we3, we_flags,
               push, pop, enable_pc, read, write, mem_req, halted, fault
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes
//   with a variable-latency memory and traps call-stack overflow/underflow.
//
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-high
//     bus    multicycle_control_unit_if.master (see interface header)
//
//   Parameters:
//     STACK_DEPTH  return-stack entries
//     WDT_CYCLES   MEM wait limit (watchdog build only)
//
//   Optional feature macro: CU_MEM_WATCHDOG_EN
//     Defined   : a MEM access waiting WDT_CYCLES cycles faults with 11.
//     Undefined : MEM waits indefinitely.
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int STACK_DEPTH = 8,
    parameter int WDT_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_HALT, C_ALU, C_J, C_JG, C_JGS, C_JAL, C_JR,
        C_JZ, C_JNZ, C_LDI, C_LD, C_LDR, C_STRR, C_STR, C_STI
    } iclass_t;

    state_t          r_state;
    logic [DW-1:0]   r_depth;
    logic [1:0]      r_fault;
    iclass_t         w_cls;
    logic            w_is_mem;
    logic            w_is_load;
    logic            w_push_trap;
    logic            w_pop_trap;
    logic            w_unused_carry;

    assign w_unused_carry = bus.carry;

`ifdef CU_MEM_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] r_wdt;
    logic          w_wdt_trip;
    // Trips on the cycle the count would reach WDT_CYCLES; mem_ready that
    // same cycle is tested first and wins.
    assign w_wdt_trip = (r_wdt == WW'(WDT_CYCLES - 1));
`else
    logic [31:0] w_unused_wdt;
    assign w_unused_wdt = 32'(WDT_CYCLES);
`endif

    // Opcode classification; unlisted encodings fall through as NOP.
    always_comb begin
        w_cls = C_NOP;
        casez (bus.opcode)
            6'b000001: w_cls = C_HALT;
            6'b111???: w_cls = C_ALU;
            6'b110000: w_cls = C_J;
            6'b110001: w_cls = C_JG;
            6'b110100: w_cls = C_JGS;
            6'b110101: w_cls = C_JAL;
            6'b11011?: w_cls = C_JR;
            6'b110011: w_cls = C_JZ;
            6'b110010: w_cls = C_JNZ;
            6'b101000: w_cls = C_LDI;
            6'b1011??: w_cls = C_LD;
            6'b101011: w_cls = C_LDR;
            6'b101010: w_cls = C_STRR;
            6'b1000??: w_cls = C_STR;
            6'b1001??: w_cls = C_STI;
            default:   w_cls = C_NOP;
        endcase
    end

    assign w_is_load   = (w_cls == C_LD) || (w_cls == C_LDR);
    assign w_is_mem    = w_is_load || (w_cls == C_STR) || (w_cls == C_STRR) || (w_cls == C_STI);
    assign w_push_trap = (w_cls == C_JAL) && (r_depth == DW'(STACK_DEPTH));
    assign w_pop_trap  = (w_cls == C_JR) && (r_depth == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_depth <= '0;
            r_fault <= '0;
`ifdef CU_MEM_WATCHDOG_EN
            r_wdt   <= '0;
`endif
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_cls == C_HALT)  r_state <= S_HALTED;
                    else if (w_is_mem)    r_state <= S_MEM;
                    else                  r_state <= S_EXEC;
`ifdef CU_MEM_WATCHDOG_EN
                    r_wdt <= '0;
`endif
                end
                S_EXEC: begin
                    if (w_push_trap) begin
                        r_fault <= 2'b01;
                        r_state <= S_HALTED;
                    end else if (w_pop_trap) begin
                        r_fault <= 2'b10;
                        r_state <= S_HALTED;
                    end else begin
                        if (w_cls == C_JAL)     r_depth <= r_depth + DW'(1);
                        else if (w_cls == C_JR) r_depth <= r_depth - DW'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= w_is_load ? S_WB : S_FETCH;
                    end
`ifdef CU_MEM_WATCHDOG_EN
                    else if (w_wdt_trip) begin
                        r_fault <= 2'b11;
                        r_state <= S_HALTED;
                    end else begin
                        r_wdt <= r_wdt + WW'(1);
                    end
`endif
                end
                S_WB: r_state <= S_FETCH;
                S_HALTED: begin
                    if (bus.resume && (r_fault == 2'b00)) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from state and opcode; flags only matter in EXEC and
    // mem_ready only in MEM. Async reset forces FETCH, so mem_req drops at once.
    always_comb begin
        bus.ir_load   = 1'b0;
        bus.s_pc      = 2'b00;
        bus.s_wd3     = 2'b00;
        bus.s_addr    = 1'b0;
        bus.s_io_wr   = 1'b0;
        bus.op_alu    = 3'b000;
        bus.we3       = 1'b0;
        bus.we_flags  = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.enable_pc = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.halted    = 1'b0;
        bus.fault     = r_fault;
        case (r_state)
            S_FETCH: bus.ir_load = 1'b1;
            S_EXEC: begin
                bus.enable_pc = 1'b1;
                case (w_cls)
                    C_ALU: begin
                        bus.we3      = 1'b1;
                        bus.we_flags = 1'b1;
                        bus.op_alu   = bus.opcode[2:0];
                    end
                    C_LDI: begin
                        bus.we3   = 1'b1;
                        bus.s_wd3 = 2'b01;
                    end
                    C_J:   bus.s_pc = 2'b01;
                    C_JZ:  bus.s_pc = bus.zero ? 2'b01 : 2'b00;
                    C_JNZ: bus.s_pc = bus.zero ? 2'b00 : 2'b01;
                    C_JG:  bus.s_pc = (~bus.zero & ~bus.sign) ? 2'b01 : 2'b00;
                    C_JGS: bus.s_pc = (~bus.zero & ~(bus.sign ^ bus.overflow)) ? 2'b01 : 2'b00;
                    C_JAL: begin
                        if (w_push_trap) bus.enable_pc = 1'b0;
                        else begin
                            bus.push = 1'b1;
                            bus.s_pc = 2'b01;
                        end
                    end
                    C_JR: begin
                        if (w_pop_trap) bus.enable_pc = 1'b0;
                        else begin
                            bus.pop  = 1'b1;
                            bus.s_pc = 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                case (w_cls)
                    C_LD:   begin bus.read = 1'b1; bus.s_addr = 1'b1; bus.s_wd3 = 2'b10; end
                    C_LDR:  begin bus.read = 1'b1; bus.s_wd3 = 2'b10; end
                    C_STR:  begin bus.write = 1'b1; bus.s_addr = 1'b1; end
                    C_STRR: bus.write = 1'b1;
                    C_STI:  begin bus.write = 1'b1; bus.s_addr = 1'b1; bus.s_io_wr = 1'b1; end
                    default: ;
                endcase
                // Stores retire in the completing MEM cycle; loads retire in WB.
                bus.enable_pc = bus.mem_ready & ~w_is_load;
            end
            S_WB: begin
                bus.we3       = 1'b1;
                bus.s_wd3     = 2'b10;
                bus.enable_pc = 1'b1;
            end
            S_HALTED: bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Directed bench for multicycle_control_unit with STACK_DEPTH = 2 and
//   WDT_CYCLES = 4. Expected output vectors are written by hand per step.
//   Vector field order: ir_load, s_pc, s_wd3, s_addr, s_io_wr, op_alu, we3,
//   we_flags, push, pop, enable_pc, read, write, mem_req, halted, fault.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .STACK_DEPTH (2),
        .WDT_CYCLES  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {bus.ir_load, bus.s_pc, bus.s_wd3, bus.s_addr, bus.s_io_wr,
                  bus.op_alu, bus.we3, bus.we_flags, bus.push, bus.pop,
                  bus.enable_pc, bus.read, bus.write, bus.mem_req,
                  bus.halted, bus.fault};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ir, input logic [1:0] spc,
                       input logic [1:0] swd, input logic sa, input logic sio,
                       input logic [2:0] op, input logic we3, input logic wef,
                       input logic psh, input logic pp, input logic en,
                       input logic rd, input logic wr, input logic req,
                       input logic hlt, input logic [1:0] flt);
        logic [20:0] exp_v;
        #1;
        exp_v = {ir, spc, swd, sa, sio, op, we3, wef, psh, pp, en, rd, wr, req, hlt, flt};
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.opcode = 6'b000000;
        bus.zero = 1'b0; bus.sign = 1'b0; bus.carry = 1'b0; bus.overflow = 1'b0;
        bus.mem_ready = 1'b0;
        bus.resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        reset = 1'b0;

        // ALU 111010 with zero=1; stray mem_ready outside MEM is ignored
        bus.opcode = 6'b111010; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        chk("alu_c0_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tick; chk("alu_c1_decode", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tick; chk("alu_c2_exec", 0,0,0,0,0,3'b010,1,1,0,0,1,0,0,0,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("alu_c3_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        bus.opcode = 6'b110010; bus.zero = 1'b1;
        tick; tick; chk("jnz_z1", 0,2'b00,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        tick;
        bus.opcode = 6'b110011; bus.zero = 1'b1;
        tick; tick; chk("jz_z1", 0,2'b01,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        tick;
        bus.opcode = 6'b110100; bus.zero = 1'b0; bus.sign = 1'b1; bus.overflow = 1'b1;
        tick; tick; chk("jgs_s1_v1", 0,2'b01,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        tick;
        bus.opcode = 6'b110001; bus.overflow = 1'b0;
        tick; tick; chk("jg_s1", 0,2'b00,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        tick;
        bus.opcode = 6'b101000;
        tick; tick; chk("ldi", 0,0,2'b01,0,0,0,1,0,0,0,1,0,0,0,0,0);
        tick;
        bus.opcode = 6'b001111;
        tick; tick; chk("undef_as_nop", 0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        tick;

        // LD 101100, mem_ready on the 4th MEM cycle -> 7 cycles total
        bus.opcode = 6'b101100;
        tick; chk("ld_decode", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) begin
            tick; chk("ld_mem_wait", 0,0,2'b10,1,0,0,0,0,0,0,0,1,0,1,0,0);
        end
        tick; bus.mem_ready = 1'b1;
        chk("ld_mem_ready", 0,0,2'b10,1,0,0,0,0,0,0,0,1,0,1,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("ld_wb", 0,0,2'b10,0,0,0,1,0,0,0,1,0,0,0,0,0);
        tick; chk("ld_next_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        bus.opcode = 6'b101011;
        tick; tick; bus.mem_ready = 1'b1;
        chk("ldr_mem", 0,0,2'b10,0,0,0,0,0,0,0,0,1,0,1,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("ldr_wb", 0,0,2'b10,0,0,0,1,0,0,0,1,0,0,0,0,0);
        tick;

        bus.opcode = 6'b101010;
        tick; tick; bus.mem_ready = 1'b1;
        chk("strr_mem_ready", 0,0,0,0,0,0,0,0,0,0,1,0,1,1,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("strr_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        bus.opcode = 6'b100110;
        tick; tick; chk("sti_mem_wait", 0,0,0,1,1,0,0,0,0,0,0,0,1,1,0,0);
        tick; bus.mem_ready = 1'b1;
        chk("sti_mem_ready", 0,0,0,1,1,0,0,0,0,0,1,0,1,1,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("sti_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        // STR ready on the 4th MEM cycle: completes even at the watchdog limit
        bus.opcode = 6'b100001;
        tick;
        for (int i = 0; i < 3; i++) begin
            tick; chk("str_mem_wait", 0,0,0,1,0,0,0,0,0,0,0,0,1,1,0,0);
        end
        tick; bus.mem_ready = 1'b1;
        chk("str_ready_at_limit", 0,0,0,1,0,0,0,0,0,0,1,0,1,1,0,0);
        tick; bus.mem_ready = 1'b0;
        chk("str_fetch_no_fault", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        bus.opcode = 6'b000001;
        tick; tick; chk("halt_halted", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        tick; chk("halt_hold", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        bus.resume = 1'b1;
        tick; bus.resume = 1'b0;
        chk("halt_resume_fetch", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        // Reset asserted mid-MEM
        bus.opcode = 6'b100000;
        tick; tick; tick; chk("str_mem_pre_rst", 0,0,0,1,0,0,0,0,0,0,0,0,1,1,0,0);
        #3 reset = 1'b1;
        chk("rst_mid_mem_async", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tick; chk("rst_mid_mem_clk", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        reset = 1'b0;

        // STR with mem_ready never asserted
        bus.opcode = 6'b100000;
        tick;
        for (int i = 0; i < 4; i++) begin
            tick; chk("str_nordy_wait", 0,0,0,1,0,0,0,0,0,0,0,0,1,1,0,0);
        end
`ifdef CU_MEM_WATCHDOG_EN
        tick; chk("wdt_trip", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b11);
        bus.resume = 1'b1;
        tick; chk("wdt_resume_ignored", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b11);
        bus.resume = 1'b0;
`else
        tick; chk("nowdt_wait5", 0,0,0,1,0,0,0,0,0,0,0,0,1,1,0,0);
        tick; bus.mem_ready = 1'b1;
        chk("nowdt_ready6", 0,0,0,1,0,0,0,0,0,0,1,0,1,1,0,0);
        tick; bus.mem_ready = 1'b0;
`endif
        reset = 1'b1;
        tick; reset = 1'b0;
        chk("rst_clears", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        // JR at depth 0
        bus.opcode = 6'b110110;
        tick; tick; chk("jr_trap_exec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tick; chk("jr_trap_halted", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b10);
        bus.resume = 1'b1;
        tick; chk("jr_trap_resume_ign", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b10);
        bus.resume = 1'b0;
        reset = 1'b1;
        tick; reset = 1'b0;
        chk("rst_after_jr", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        // Depth: JAL(1), JR(0), JAL(1), JAL(2), JAL traps
        bus.opcode = 6'b110101;
        tick; tick; chk("jal_1", 0,2'b01,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
        tick; bus.opcode = 6'b110111;
        tick; tick; chk("jr_pop", 0,2'b10,0,0,0,0,0,0,0,1,1,0,0,0,0,0);
        tick; bus.opcode = 6'b110101;
        tick; tick; chk("jal_2a", 0,2'b01,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
        tick;
        tick; tick; chk("jal_2b", 0,2'b01,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
        tick;
        tick; tick; chk("jal_trap_exec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        tick; chk("jal_trap_halted", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b01);
        bus.resume = 1'b1;
        tick; chk("jal_resume_ign1", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b01);
        tick; chk("jal_resume_ign2", 0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2'b01);
        bus.resume = 1'b0;
        reset = 1'b1;
        tick; reset = 1'b0;
        chk("rst_final", 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
